// File: rtl/sdram_read_sequencer.sv
// Host-side read front end for the SDRAM reader: splits a linear word address,
// runs one reader transaction, and returns the word (or a timeout error) on a valid/ready channel.
module sdram_read_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        iinit_done,
    input  logic        ireq_valid,
    input  logic [24:0] ireq_addr,
    output logic        oreq_ready,
    output logic        orsp_valid,
    output logic [15:0] orsp_data,
    output logic        orsp_err,
    input  logic        irsp_ready,
    output logic        ord_req,
    output logic        ord_enb,
    output logic [12:0] ord_row,
    output logic [9:0]  ord_column,
    output logic [1:0]  ord_bank,
    input  logic        ird_fin,
    input  logic [15:0] ird_data,
    output logic        obusy,
    output logic [15:0] ord_count
);

    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WDW-1:0] wdog;
    logic           accept;
    logic           fin_hit;
    logic           timeout_hit;

    assign oreq_ready  = (state == IDLE) && iinit_done;
    assign accept      = ireq_valid && oreq_ready;
    assign fin_hit     = (state == WAIT) && ird_fin;
    // Completion on the last watchdog cycle still counts as a success.
    assign timeout_hit = (state == WAIT) && !ird_fin && (wdog == WDW'(TIMEOUT - 1));

    // Reader strobes decode straight from the state register, so an async
    // reset drops the enable in the same instant.
    assign ord_req = (state == ISSUE);
    assign ord_enb = (state == ISSUE) || (state == WAIT);
    assign obusy   = (state != IDLE);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state <= IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block from inferring a latch on unlisted paths.
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (fin_hit || timeout_hit) state_nxt = RESP;
            RESP:  if (irsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            ord_bank   <= '0;
            ord_row    <= '0;
            ord_column <= '0;
            wdog       <= '0;
            orsp_valid <= 1'b0;
            orsp_data  <= '0;
            orsp_err   <= 1'b0;
            ord_count  <= '0;
        end else begin
            if (accept) begin
                ord_bank   <= ireq_addr[24:23];
                ord_row    <= ireq_addr[22:10];
                ord_column <= ireq_addr[9:0];
            end

            case (state)
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (fin_hit) begin
                        orsp_data  <= ird_data;
                        orsp_err   <= 1'b0;
                        orsp_valid <= 1'b1;
                        ord_count  <= ord_count + 16'd1;
                    end else if (timeout_hit) begin
                        orsp_data  <= '0;
                        orsp_err   <= 1'b1;
                        orsp_valid <= 1'b1;
                    end
                end
                RESP: if (irsp_ready) orsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_read_sequencer.sv
// Directed bench for sdram_read_sequencer: table of read transactions plus
// hand-written sequences for init gating, count wrap, and reset mid-read.
module tb_sdram_read_sequencer;

    logic        iclk = 1'b0;
    logic        ireset;
    logic        iinit_done;
    logic        ireq_valid;
    logic [24:0] ireq_addr;
    logic        oreq_ready;
    logic        orsp_valid;
    logic [15:0] orsp_data;
    logic        orsp_err;
    logic        irsp_ready;
    logic        ord_req;
    logic        ord_enb;
    logic [12:0] ord_row;
    logic [9:0]  ord_column;
    logic [1:0]  ord_bank;
    logic        ird_fin;
    logic [15:0] ird_data;
    logic        obusy;
    logic [15:0] ord_count;

    sdram_read_sequencer #(.TIMEOUT(32)) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iinit_done (iinit_done),
        .ireq_valid (ireq_valid),
        .ireq_addr  (ireq_addr),
        .oreq_ready (oreq_ready),
        .orsp_valid (orsp_valid),
        .orsp_data  (orsp_data),
        .orsp_err   (orsp_err),
        .irsp_ready (irsp_ready),
        .ord_req    (ord_req),
        .ord_enb    (ord_enb),
        .ord_row    (ord_row),
        .ord_column (ord_column),
        .ord_bank   (ord_bank),
        .ird_fin    (ird_fin),
        .ird_data   (ird_data),
        .obusy      (obusy),
        .ord_count  (ord_count)
    );

    always #5 iclk = ~iclk;

    // lat: cycles from the ord_req cycle to the ird_fin cycle (0 = reader never answers).
    // exp_j: negedge index (1 = ISSUE cycle) at which orsp_valid is first seen.
    typedef struct {
        logic [24:0] addr;
        int          lat;
        logic [15:0] rdata;
        int          hold;
        logic [1:0]  exp_bank;
        logic [12:0] exp_row;
        logic [9:0]  exp_col;
        int          exp_j;
        logic [15:0] exp_data;
        logic        exp_err;
    } rd_vec_t;

    rd_vec_t     vecs[7];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_read(input rd_vec_t v, output int waited);
        int          seen;
        int          j;
        int          req_bad;
        int          enb_bad;
        int          addr_bad;
        int          stall_bad;
        logic [15:0] held;
        seen = 0; req_bad = 0; enb_bad = 0; addr_bad = 0; stall_bad = 0;
        ireq_addr  = v.addr;
        ireq_valid = 1'b1;
        irsp_ready = 1'b0;
        ird_data   = v.rdata;
        #1;
        waited = 0;
        while (!oreq_ready && waited < 50) begin
            @(negedge iclk);
            #1;
            waited++;
        end
        check("accept", {31'd0, oreq_ready}, 32'd1);
        @(negedge iclk);
        ireq_valid = 1'b0;
        for (j = 1; j <= 60; j++) begin
            if (j > 1) @(negedge iclk);
            if (orsp_valid) begin
                seen = j;
            end else begin
                if (ord_req != (j == 1)) req_bad++;
                if (!ord_enb || !obusy || oreq_ready) enb_bad++;
                if (ord_bank != v.exp_bank || ord_row != v.exp_row || ord_column != v.exp_col) addr_bad++;
            end
            ird_fin = (v.lat != 0) && (j == v.lat + 1);
            if (seen != 0) break;
        end
        if (!v.exp_err) exp_count = exp_count + 16'd1;
        check("rsp_cycle", seen, v.exp_j);
        check("req_pulse", req_bad, 0);
        check("enb_busy_window", enb_bad, 0);
        check("addr_split", addr_bad, 0);
        check("rsp_data", {16'd0, orsp_data}, {16'd0, v.exp_data});
        check("rsp_err", {31'd0, orsp_err}, {31'd0, v.exp_err});
        check("rsp_enb_low", {31'd0, ord_enb}, 32'd0);
        check("rsp_count", {16'd0, ord_count}, {16'd0, exp_count});
        held = orsp_data;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge iclk);
            j++;
            ird_fin = (v.lat != 0) && (j == v.lat + 1);
            if (!orsp_valid || orsp_data != held || orsp_err != v.exp_err ||
                oreq_ready || ord_enb || ord_req || ord_count != exp_count) stall_bad++;
        end
        check("stall_stable", stall_bad, 0);
        irsp_ready = 1'b1;
        @(negedge iclk);
        irsp_ready = 1'b0;
        ird_fin    = 1'b0;
        check("idle_after_hs", {30'd0, obusy, orsp_valid}, 32'd0);
        check("ready_after_hs", {31'd0, oreq_ready}, {31'd0, iinit_done});
        check("addr_hold", {ord_bank, ord_row, ord_column}, {v.exp_bank, v.exp_row, v.exp_col});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int waited;
        int gate_bad;
        //         addr          lat rdata     hold bank   row       col      j   data      err
        vecs[0] = '{25'h1A2B3C4, 13, 16'hBEEF,  0, 2'd3, 13'h08AC, 10'h3C4, 15, 16'hBEEF, 1'b0};
        vecs[1] = '{25'h0000000,  1, 16'h0001,  3, 2'd0, 13'h0000, 10'h000,  3, 16'h0001, 1'b0};
        vecs[2] = '{25'h1FFFFFF,  5, 16'hFFFF, 10, 2'd3, 13'h1FFF, 10'h3FF,  7, 16'hFFFF, 1'b0};
        vecs[3] = '{25'h0800001,  2, 16'h1234,  0, 2'd1, 13'h0000, 10'h001,  4, 16'h1234, 1'b0};
        vecs[4] = '{25'h1000400, 32, 16'hA5A5,  1, 2'd2, 13'h0001, 10'h000, 34, 16'hA5A5, 1'b0};
        vecs[5] = '{25'h0155555,  0, 16'hDEAD,  2, 2'd0, 13'h0555, 10'h155, 34, 16'h0000, 1'b1};
        vecs[6] = '{25'h0C00000, 33, 16'h7777,  2, 2'd1, 13'h1000, 10'h000, 34, 16'h0000, 1'b1};

        ireset = 1'b1; iinit_done = 1'b0; ireq_valid = 1'b0; ireq_addr = '0;
        irsp_ready = 1'b0; ird_fin = 1'b0; ird_data = '0; exp_count = '0;
        repeat (2) @(negedge iclk);
        check("reset_ctrl", {oreq_ready, orsp_valid, orsp_err, ord_req, ord_enb, obusy}, 32'd0);
        check("reset_data", {orsp_data, ord_count}, 32'd0);
        check("reset_addr", {ord_bank, ord_row, ord_column}, 32'd0);
        ireset = 1'b0;

        // Requests are held off while initialisation is incomplete.
        ireq_valid = 1'b1;
        ireq_addr  = vecs[0].addr;
        gate_bad   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iclk);
            if (oreq_ready || ord_req || obusy) gate_bad++;
        end
        check("init_gate", gate_bad, 0);
        iinit_done = 1'b1;
        do_read(vecs[0], waited);
        check("init_same_cycle", waited, 0);

        for (int i = 1; i < 7; i++) do_read(vecs[i], waited);

        // A stray completion while idle must be ignored.
        @(negedge iclk);
        ird_fin  = 1'b1;
        ird_data = 16'h5555;
        @(negedge iclk);
        ird_fin = 1'b0;
        @(negedge iclk);
        check("idle_fin_ignored", {orsp_valid, obusy, ord_count}, {2'b00, exp_count});

        force dut.ord_count = 16'hFFFF;
        #1;
        release dut.ord_count;
        exp_count = 16'hFFFF;
        do_read(vecs[1], waited);
        check("count_wrap", {16'd0, ord_count}, 32'd0);

        // Reset in WAIT abandons the read immediately.
        @(negedge iclk);
        ireq_addr  = vecs[2].addr;
        ireq_valid = 1'b1;
        @(negedge iclk);
        ireq_valid = 1'b0;
        repeat (3) @(negedge iclk);
        check("pre_reset_wait", {obusy, ord_enb, ord_req}, 32'b110);
        ireset = 1'b1;
        #1;
        check("reset_midread", {obusy, ord_enb, orsp_valid}, 32'd0);
        exp_count = '0;
        @(negedge iclk);
        ireset   = 1'b0;
        ird_fin  = 1'b1;
        ird_data = 16'h9999;
        gate_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iclk);
            ird_fin = 1'b0;
            if (orsp_valid || obusy || ord_count != 16'd0) gate_bad++;
        end
        check("no_rsp_after_reset", gate_bad, 0);
        do_read(vecs[3], waited);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
